nes_bus_dma: RTL and testbench

CPU-side bus stage directly downstream of the 6502 core. It decodes the core's address/rd/we bus into NES memory-map chip selects with mirroring folded in, and returns read data to the core. It also implements the $4014 OAM DMA engine: it stalls the core and copies 256 bytes from page V×$100 to PPU $2004.

---
 rtl/nes_bus_pkg.sv | 26 ++
 rtl/nes_addr_decode.sv | 18 +
 rtl/nes_bus_dma.sv | 83 ++++++++
 tb/tb_nes_bus_dma.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: NES CPU memory-map constants, OAM DMA states and chip-select encoding.
package nes_bus_pkg;

    localparam logic [15:0] PPU_BASE = 16'h2000;
    localparam logic [15:0] IO_BASE  = 16'h4000;
    localparam logic [15:0] ROM_BASE = 16'h4020;
    localparam logic [15:0] DMA_PORT = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;
    localparam logic [15:0] RAM_MASK = 16'h07FF;

    typedef enum logic [2:0] {
        IDLE,
        DUMMY,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    typedef struct packed {
        logic ram;
        logic ppu;
        logic io;
        logic rom;
    } cs_t;

endpackage

// File: rtl/nes_addr_decode.sv
// nes_addr_decode: folds NES CPU addresses through RAM/PPU mirroring and raises the matching region select.
module nes_addr_decode
    import nes_bus_pkg::*;
(
    input  logic [15:0] address,
    output logic [15:0] mapped,
    output cs_t         cs
);

    assign cs.ram = address < PPU_BASE;
    assign cs.ppu = address >= PPU_BASE && address < IO_BASE;
    assign cs.io  = address >= IO_BASE && address < ROM_BASE;
    assign cs.rom = address >= ROM_BASE;
    assign mapped = cs.ram ? (address & RAM_MASK)
                  : cs.ppu ? (PPU_BASE | {13'd0, address[2:0]})
                  : address;

endmodule

// File: rtl/nes_bus_dma.sv
// nes_bus_dma: CPU bus decode stage with the $4014 OAM DMA engine that stalls the core
// and streams a 256-byte page into the PPU OAM data port.
module nes_bus_dma
    import nes_bus_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    output logic [7:0]  cpu_data,
    output logic        cpu_ready,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_out,
    input  logic [7:0]  mem_in,
    output logic        mem_rd,
    output logic        mem_we,
    output logic        ram_cs,
    output logic        ppu_cs,
    output logic        io_cs,
    output logic        rom_cs,
    output logic        dma_busy
);

    dma_state_t  state, next;
    logic [7:0]  count, page;
    logic        parity, odd, trigger;
    logic [15:0] dec_address;
    cs_t         dec_cs;

    assign trigger     = state == IDLE && cpu_we && cpu_address == DMA_PORT;
    assign dec_address = state == READ ? {page, count} : state == WRITE ? OAM_DATA : cpu_address;

    nes_addr_decode u_decode (
        .address (dec_address),
        .mapped  (mem_address),
        .cs      (dec_cs)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            page   <= '0;
            parity <= 1'b0;
            odd    <= 1'b0;
        end else begin
            state  <= next;
            parity <= ~parity;
            if (trigger) begin
                page <= cpu_out;
                odd  <= parity;
            end
            // 8-bit wrap returns the counter to 0 on the final WRITE
            if (state == WRITE)
                count <= count + 8'd1;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = trigger ? DUMMY : IDLE;
            DUMMY:   next = odd ? ALIGN : READ;
            ALIGN:   next = READ;
            READ:    next = WRITE;
            WRITE:   next = count == 8'hFF ? IDLE : READ;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = state == IDLE;
        dma_busy  = state != IDLE;
        cpu_data  = mem_in;
        mem_rd    = state == IDLE ? cpu_rd & ~cpu_we : state == READ;
        mem_we    = state == IDLE ? cpu_we & ~trigger : state == WRITE;
        mem_out   = state == WRITE ? mem_in : cpu_out;
        {ram_cs, ppu_cs, io_cs, rom_cs} = (mem_rd | mem_we) ? dec_cs : 4'b0000;
    end

endmodule

// File: tb/tb_nes_bus_dma.sv
// tb_nes_bus_dma: scoreboard bench for CPU decode and OAM DMA; expected bus
// transactions and stall lengths are queued by stimulus and checked by a monitor.
module tb_nes_bus_dma;

    logic        clock = 1'b0, reset = 1'b1;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_out = '0;
    logic        cpu_rd = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_data;
    logic        cpu_ready;
    logic [15:0] mem_address;
    logic [7:0]  mem_out;
    logic [7:0]  mem_in = 8'h00;
    logic        mem_rd, mem_we;
    logic        ram_cs, ppu_cs, io_cs, rom_cs;
    logic        dma_busy;

    typedef struct packed {
        logic        rd;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [3:0]  cs;
    } txn_t;

    txn_t exp_q[$];
    int   stall_q[$];
    int   applied = 0, miscompares = 0;
    logic tpar;

    nes_bus_dma dut (
        .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
        .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .mem_address(mem_address), .mem_out(mem_out), .mem_in(mem_in), .mem_rd(mem_rd),
        .mem_we(mem_we), .ram_cs(ram_cs), .ppu_cs(ppu_cs), .io_cs(io_cs), .rom_cs(rom_cs),
        .dma_busy(dma_busy)
    );

    always #5 clock = ~clock;

    // Synchronous device model: every byte reads back as its low address byte ^ $A5
    always @(posedge clock) mem_in <= mem_rd ? (mem_address[7:0] ^ 8'hA5) : 8'h00;

    always @(posedge clock or posedge reset) tpar <= reset ? 1'b0 : ~tpar;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        txn_t e;
        int   stall_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_cnt = 0;
            end else begin
                if (mem_rd || mem_we) begin
                    if (exp_q.size() == 0) begin
                        applied++;
                        miscompares++;
                        $display("FAIL unexpected_txn: got rd=%b we=%b addr=%h, expected none", mem_rd, mem_we, mem_address);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn", {mem_rd, mem_we, mem_address, ram_cs, ppu_cs, io_cs, rom_cs},
                              {e.rd, e.we, e.addr, e.cs});
                        if (e.we) check("wdata", mem_out, e.data);
                    end
                end else begin
                    check("idle_cs", {ram_cs, ppu_cs, io_cs, rom_cs}, 4'b0000);
                end
                if (!cpu_ready) begin
                    stall_cnt++;
                end else if (stall_cnt > 0) begin
                    if (stall_q.size() == 0) begin
                        applied++;
                        miscompares++;
                        $display("FAIL unexpected_stall: got %0d cycles, expected none", stall_cnt);
                    end else begin
                        check("stall_len", stall_cnt, stall_q.pop_front());
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // All driver tasks enter and leave 1 time unit after a rising edge
    task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic we,
                          input logic e_rd, input logic [15:0] e_addr, input logic [3:0] e_cs,
                          input logic [7:0] e_rdata);
        exp_q.push_back('{e_rd, we, e_addr, d, e_cs});
        cpu_address = a; cpu_out = d; cpu_rd = rd; cpu_we = we;
        @(posedge clock); #1;
        cpu_rd = 0; cpu_we = 0; cpu_address = '0; cpu_out = '0;
        if (e_rd) check("cpu_data", cpu_data, e_rdata);
    endtask

    task automatic dma(input logic [7:0] page, input logic want_odd, input int nbytes, input bit full);
        logic [15:0] a;
        logic [3:0]  cs;
        while (tpar != want_odd) begin @(posedge clock); #1; end
        if (full) stall_q.push_back(want_odd ? 514 : 513);
        for (int k = 0; k < nbytes; k++) begin
            case (page)
                8'h21:   begin a = 16'h2000 | 16'(k % 8); cs = 4'b0100; end
                8'hC0:   begin a = 16'hC000 + 16'(k);    cs = 4'b0001; end
                default: begin a = {page, 8'(k)};        cs = 4'b1000; end
            endcase
            exp_q.push_back('{1'b1, 1'b0, a, 8'h00, cs});
            exp_q.push_back('{1'b0, 1'b1, 16'h2004, a[7:0] ^ 8'hA5, 4'b0100});
        end
        cpu_address = 16'h4014; cpu_out = page; cpu_we = 1;
        #1;
        check("trig_mem_we", mem_we, 0);
        check("trig_io_cs", io_cs, 0);
        check("trig_ready", cpu_ready, 1);
        @(posedge clock); #1;
        cpu_we = 0; cpu_address = '0; cpu_out = '0;
        check("dma_busy", dma_busy, 1);
        check("dma_ready", cpu_ready, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || stall_q.size() != 0 || !cpu_ready) && n < 1200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 1200) begin
            applied++;
            miscompares++;
            $display("FAIL dma_timeout: got %0d txns and %0d stalls pending, expected 0", exp_q.size(), stall_q.size());
            exp_q.delete();
            stall_q.delete();
        end
    endtask

    initial begin : stimulus
        int n;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", cpu_ready, 1);
        check("rst_busy", dma_busy, 0);
        check("rst_strobes", {mem_rd, mem_we, ram_cs, ppu_cs, io_cs, rom_cs}, 0);
        reset = 0;
        @(posedge clock); #1;

        cpu_op(16'h0801, 8'h00, 1, 0, 1, 16'h0001, 4'b1000, 8'hA4);
        cpu_op(16'h1FFF, 8'h5A, 0, 1, 0, 16'h07FF, 4'b1000, 8'h00);
        cpu_op(16'h3FFE, 8'h00, 1, 0, 1, 16'h2006, 4'b0100, 8'hA3);
        cpu_op(16'h4015, 8'h0F, 1, 1, 0, 16'h4015, 4'b0010, 8'h00);
        cpu_op(16'h4014, 8'h00, 1, 0, 1, 16'h4014, 4'b0010, 8'hB1);
        check("rd4014_busy", dma_busy, 0);
        check("rd4014_ready", cpu_ready, 1);

        dma(8'h02, 0, 256, 1); wait_done();
        dma(8'h02, 1, 256, 1); wait_done();
        dma(8'hC0, 0, 256, 1); wait_done();
        dma(8'h21, 1, 256, 1); wait_done();

        // Abort: reset lands in the READ of byte 100
        dma(8'h02, 0, 100, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge clock); #1; n++; end
        check("abort_pre_rd", {mem_rd, mem_address}, {1'b1, 16'h0264});
        reset = 1;
        #1;
        check("abort_ready", cpu_ready, 1);
        check("abort_busy", dma_busy, 0);
        check("abort_strobes", {mem_rd, mem_we, ram_cs, ppu_cs, io_cs, rom_cs}, 0);
        @(posedge clock); #1;
        reset = 0;
        @(posedge clock); #1;
        dma(8'h02, 0, 256, 1); wait_done();

        repeat (3) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
